// File: rtl/edge_ts_pkg.sv
// Shared constants for the edge_timestamp capture stage: parameter defaults,
// source-bit positions and the FIFO entry width helper.
package edge_ts_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 4;

  // Bit positions inside the src/lvl fields
  localparam int SRC_A = 0;
  localparam int SRC_B = 1;

  // Each entry is {ts, src[1:0], lvl[1:0]}
  localparam int ENTRY_META_W = 4;

  function automatic int entry_w(input int ts_w);
    return ts_w + ENTRY_META_W;
  endfunction

endpackage

// File: rtl/edge_ts_if.sv
// Valid/ready event port of edge_timestamp. The master drives the head
// entry; the slave (consumer) drives evt_ready.
interface edge_ts_if
  import edge_ts_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
);

  logic            evt_valid;
  logic            evt_ready;
  logic [TS_W-1:0] evt_ts;
  logic [1:0]      evt_src;
  logic [1:0]      evt_lvl;

  modport master (
    output evt_valid,
    output evt_ts,
    output evt_src,
    output evt_lvl,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ts,
    input  evt_src,
    input  evt_lvl,
    output evt_ready
  );

endinterface

// File: rtl/edge_ts_fifo.sv
// Small synchronous FIFO holding timestamped events. Pointers carry one
// extra wrap bit so full and empty are distinguished without a counter.
// A push while full is accepted only if a pop happens in the same cycle.
module edge_ts_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer advance on accepted push/pop
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
    if (do_pop)  rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
  end

  // Pointer registers; reset empties the queue immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  // Head entry is visible combinationally so valid and data rise together
  assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/edge_timestamp.sv
// Edge capture stage: detects transitions on sig_a/sig_b, stamps each event
// with a free-running cycle count and queues {ts, src, lvl} for a
// valid/ready consumer. Dropped events set the sticky ovf flag.
// Build option: define EDGE_TS_SYNC_EN to add a two-flop synchronizer in
// front of each sample flop (adds two cycles of latency and timestamp).
module edge_timestamp
  import edge_ts_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      sig_a,
  input  logic      sig_b,
  edge_ts_if.master evt,
  output logic      ovf,
  input  logic      ovf_clr
);

  localparam int EW = entry_w(TS_W);

  logic [1:0]      sig_in;
  logic [1:0]      samp;
  logic [1:0]      s0_reg, p_reg;
  logic [1:0]      edge_vec;
  logic [TS_W-1:0] ts_cnt_reg, ts_cnt_next;
  logic            ovf_reg, ovf_next;
  logic            push, pop, drop;
  logic            fifo_full, fifo_empty;
  logic [EW-1:0]   fifo_din, fifo_dout;

  assign sig_in[SRC_A] = sig_a;
  assign sig_in[SRC_B] = sig_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in
`ifdef EDGE_TS_SYNC_EN
      logic sync1_reg, sync2_reg;
      // Two-flop synchronizer for inputs not timed to clk
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= sig_in[gi];
          sync2_reg <= sync1_reg;
        end
      end
      assign samp[gi] = sync2_reg;
`else
      assign samp[gi] = sig_in[gi];
`endif
    end
  endgenerate

  // Sample and history flops feeding the edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_reg <= '0;
      p_reg  <= '0;
    end else begin
      s0_reg <= samp;
      p_reg  <= s0_reg;
    end
  end

  assign edge_vec = s0_reg ^ p_reg;
  assign push     = |edge_vec;
  assign pop      = evt.evt_ready && !fifo_empty;
  assign drop     = push && fifo_full && !pop;
  assign fifo_din = {ts_cnt_reg, edge_vec, s0_reg};

  // Counter wraps silently; overflow set takes priority over clear
  always_comb begin
    ts_cnt_next = ts_cnt_reg + TS_W'(1);
    ovf_next    = (ovf_reg && !ovf_clr) || drop;
  end

  // Timestamp counter and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      ts_cnt_reg <= ts_cnt_next;
      ovf_reg    <= ovf_next;
    end
  end

  edge_ts_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign ovf           = ovf_reg;
  assign evt.evt_valid = !fifo_empty;
  assign {evt.evt_ts, evt.evt_src, evt.evt_lvl} = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_edge_timestamp.sv
// Directed bench for edge_timestamp (TS_W = 8 so the wrap case is short).
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_edge_timestamp;

  localparam int TS_W = 8;
`ifdef EDGE_TS_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk, rst_n, sig_a, sig_b, ovf, ovf_clr;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc;
  int   c0;

  edge_ts_if #(.TS_W(TS_W)) evt_if ();

  edge_timestamp #(
    .TS_W  (TS_W),
    .DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_a   (sig_a),
    .sig_b   (sig_b),
    .evt     (evt_if),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Cycles since reset release, used only to place relative timestamps
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Expected ts for an input changed at a falling edge where cyc == c
  function automatic logic [TS_W-1:0] ts_of(input int c);
    return TS_W'(c + 1 + L);
  endfunction

  // Check the head entry, then pop it with a one-cycle ready pulse
  task automatic pop_expect(input string tag, input logic [TS_W-1:0] ets,
                            input logic [1:0] esrc, input logic [1:0] elvl);
    check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'(1'b1));
    check({tag, "_ts"},    32'(evt_if.evt_ts),    32'(ets));
    check({tag, "_src"},   32'(evt_if.evt_src),   32'(esrc));
    check({tag, "_lvl"},   32'(evt_if.evt_lvl),   32'(elvl));
    $display("EVT %s ts=%0d src=%b lvl=%b", tag, evt_if.evt_ts, evt_if.evt_src, evt_if.evt_lvl);
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    evt_if.evt_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sig_a = 1'b0; sig_b = 1'b0; ovf_clr = 1'b0;
    evt_if.evt_ready = 1'b0;

    // Reset state
    #25;
    check("rst_valid", 32'(evt_if.evt_valid), 32'(1'b0));
    check("rst_ts",    32'(evt_if.evt_ts),    32'(0));
    check("rst_src",   32'(evt_if.evt_src),   32'(0));
    check("rst_lvl",   32'(evt_if.evt_lvl),   32'(0));
    check("rst_ovf",   32'(ovf),              32'(1'b0));
    #6 rst_n = 1'b1;

    // Single rise on A at 100 ns: ts 4, valid exactly 2 edges later
    repeat (4) @(negedge clk);
    sig_a = 1'b1;
    repeat (1 + L) @(negedge clk);
    check("rise_early", 32'(evt_if.evt_valid), 32'(1'b0));
    @(negedge clk);
    pop_expect("rise", TS_W'(4 + L), 2'b01, 2'b01);
    check("rise_once", 32'(evt_if.evt_valid), 32'(1'b0));
    repeat (2) @(negedge clk);
    check("rise_quiet", 32'(evt_if.evt_valid), 32'(1'b0));

    // Simultaneous A fall and B rise -> one entry, src 11
    c0 = cyc; sig_a = 1'b0; sig_b = 1'b1;
    repeat (2 + L) @(negedge clk);
    pop_expect("simul", ts_of(c0), 2'b11, 2'b10);
    check("simul_once", 32'(evt_if.evt_valid), 32'(1'b0));

    // Five back-to-back A toggles into a 4-deep FIFO -> overflow
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      sig_a = ~sig_a;
      @(negedge clk);
    end
    repeat (1 + L) @(negedge clk);
    check("b2b_ovf", 32'(ovf), 32'(1'b1));
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("b2b_ovf_clr", 32'(ovf), 32'(1'b0));
    pop_expect("b2b0", ts_of(c0),     2'b01, 2'b11);
    pop_expect("b2b1", ts_of(c0 + 1), 2'b01, 2'b10);
    pop_expect("b2b2", ts_of(c0 + 2), 2'b01, 2'b11);
    pop_expect("b2b3", ts_of(c0 + 3), 2'b01, 2'b10);
    check("b2b_dropped", 32'(evt_if.evt_valid), 32'(1'b0));

    // Fill with four B toggles, then push and pop in the same cycle
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      sig_b = ~sig_b;
      @(negedge clk);
    end
    repeat (1 + L) @(negedge clk);
    check("full_ovf", 32'(ovf), 32'(1'b0));
    begin
      int cn;
      cn = cyc; sig_a = 1'b0;
      repeat (1 + L) @(negedge clk);
      pop_expect("full0", ts_of(c0), 2'b10, 2'b01);
      check("full_pp_ovf", 32'(ovf), 32'(1'b0));
      pop_expect("full1", ts_of(c0 + 1), 2'b10, 2'b11);
      pop_expect("full2", ts_of(c0 + 2), 2'b10, 2'b01);
      pop_expect("full3", ts_of(c0 + 3), 2'b10, 2'b11);
      pop_expect("full4", ts_of(cn),     2'b01, 2'b10);
      check("full_empty", 32'(evt_if.evt_valid), 32'(1'b0));
    end

    // Timestamp wrap: event at 255, next two cycles later at 1
    for (int i = 0; i < 400 && (cyc % 256) != (254 - L); i++) @(negedge clk);
    check("wrap_reach", 32'(cyc % 256), 32'(254 - L));
    sig_a = 1'b1;
    repeat (2) @(negedge clk);
    sig_a = 1'b0;
    repeat (2 + L) @(negedge clk);
    pop_expect("wrap0", TS_W'(255), 2'b01, 2'b11);
    pop_expect("wrap1", TS_W'(1),   2'b01, 2'b10);

    // Reset mid-drain, with A held high across the release
    c0 = cyc; sig_a = 1'b1;
    @(negedge clk);
    sig_a = 1'b0;
    repeat (1 + L) @(negedge clk);
    pop_expect("mid0", ts_of(c0), 2'b01, 2'b11);
    check("mid_pending", 32'(evt_if.evt_valid), 32'(1'b1));
    #5 rst_n = 1'b0; sig_a = 1'b1; sig_b = 1'b0;
    #1;
    check("arst_valid", 32'(evt_if.evt_valid), 32'(1'b0));
    check("arst_ts",    32'(evt_if.evt_ts),    32'(0));
    check("arst_src",   32'(evt_if.evt_src),   32'(0));
    check("arst_lvl",   32'(evt_if.evt_lvl),   32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (1 + L) @(negedge clk);
    check("rel_early", 32'(evt_if.evt_valid), 32'(1'b0));
    @(negedge clk);
    pop_expect("rel", TS_W'(1 + L), 2'b01, 2'b01);
    repeat (3) @(negedge clk);
    check("rel_once", 32'(evt_if.evt_valid), 32'(1'b0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/edge_timestamp.md
# edge_timestamp

Event-capture stage that watches two single-bit stimulus/status lines (`sig_a`, `sig_b`), detects every transition on either, and stamps each event with a free-running cycle count. Events are queued in a small FIFO and drained over a valid/ready port. It sits directly downstream of the stimulus generator in the `testbench_top`-style simulation environment, and of equivalent on-board signal sources. It turns "when did A/B change" into cycle-accurate records that can be displayed, logged or compared.

## Interface
- `TS_W`, 16: timestamp counter width in bits, range 8–32.
- `DEPTH`, 4: FIFO entries; must be a power of 2, range 2–16.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset; async assert, release synchronous to `clk`.
- `sig_a`  in  1  monitored line A.
- `sig_b`  in  1  monitored line B.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head this cycle.
- `evt_ts`  out  TS_W  timestamp of the head event.
- `evt_src`  out  2  source flags of the head event; bit0 = A changed, bit1 = B changed.
- `evt_lvl`  out  2  post-transition levels of {B, A} for the head event.
- `ovf`  out  1  sticky flag: an event was dropped.
- `ovf_clr`  in  1  single-cycle clear for `ovf`.

## Operation
- `ts_cnt` (TS_W) resets to 0 and increments every cycle. It wraps from 2^TS_W−1 to 0 with no flag.
- Each input passes through a sample flop `s0`, then a history flop `p`. An edge is detected when `s0 ^ p` is nonzero for that input.
- On any edge, one entry {ts, src, lvl} is pushed:
  - ts = `ts_cnt` value during the detect cycle.
  - src = the `s0 ^ p` vector.
  - lvl = `s0`.
- Simultaneous A and B edges produce a single entry with src = 2'b11.
- Pop occurs when `evt_valid && evt_ready`.
- When `evt_valid` = 0, `evt_ts`, `evt_src` and `evt_lvl` are driven to 0.
- FIFO behaviour by fill level:
  - Full, push, no pop: the entry is dropped and `ovf` is set.
  - Full, push and pop in the same cycle: the push is accepted and `ovf` is unchanged.
  - Empty, push: `evt_valid` rises the next cycle. There is no same-cycle bypass.
- `ovf_clr` and a new overflow in the same cycle: set wins.
- Reset values:
  - `evt_valid`, `evt_ts`, `evt_src`, `evt_lvl` and `ovf` are all 0.
  - `ts_cnt` is 0 and the FIFO is empty.
  - All sample, history and synchronizer flops are 0.
- Reset mid-operation discards every queued entry immediately.
- An input that is high when reset releases produces one rising event, with lvl bit = 1, at the normal latency.

## Timing
- Input transition sampled at edge E:
  - `s0` updates at E.
  - Edge is detected during cycle E→E+1; ts = `ts_cnt` in that cycle.
  - Entry is written at E+1.
  - `evt_valid` is high after E+1 if the FIFO was empty.
- With `EDGE_TS_SYNC_EN`, every point above moves two cycles later: write at E+3.
- Sustained throughput: one event per cycle in, one per cycle out.
- Input pulses shorter than one clock period may be missed. This is by design.

## Configuration
- `EDGE_TS_SYNC_EN` defined:
  - A two-flop synchronizer sits in front of each `s0`, for asynchronous or board-level inputs.
  - Detect-to-input latency is 3 cycles.
  - Timestamps are 2 counts later than without the macro.
- Undefined:
  - Inputs are treated as synchronous to `clk`.
  - Write occurs at E+1.
  - The synchronizer flops are not instantiated.

## Structure
- Shared package `edge_ts_pkg` contains:
  - Defaults `TS_W_DEF = 16` and `DEPTH_DEF = 4`.
  - Source bit indices `SRC_A = 0` and `SRC_B = 1`.
  - The entry-width constant, TS_W + 4.
- One sub-module, `edge_ts_fifo`:
  - Synchronous FIFO with parameters width and depth.
  - Ports: push, pop, full, empty, data in and data out.
  - Pointers carry one extra wrap bit.
- Edge detect, counter and overflow logic stay in the top module.

## Test plan
All directed scenarios use a 20 ns clock with reset released at 30 ns; the macro is undefined unless stated.
- **Single rise:** `sig_a` 0→1 at 100 ns, `evt_ready` = 1 → exactly one event with src = 01, lvl = 01, and ts = `ts_cnt` in the detect cycle (expected 4 under this reset timing).
- **Simultaneous change:** `sig_a` and `sig_b` change in the same cycle → one entry with src = 11.
- **Back-to-back toggles:** with `evt_ready` = 0, A toggles 5 times on consecutive cycles and DEPTH = 4 →
  - first 4 entries hold consecutive ts values with alternating lvl;
  - `ovf` = 1;
  - `ovf_clr` pulse returns `ovf` to 0.
- **Full with concurrent pop:** FIFO full, push and pop in the same cycle → no overflow; order preserved on drain.
- **Wrap:** TS_W = 8, event at count 255 and next event 2 cycles later → ts 255, then 1.
- **Reset and synchronizer:**
  - Reset asserted mid-drain → all outputs 0 immediately.
  - Input held high across reset release → one event after release.
  - With `EDGE_TS_SYNC_EN` → same input gives ts +2 and `evt_valid` 2 cycles later.
